// File: rtl/double_max_stream.sv
// double_max_stream: streaming arg-max over frames of IEEE-754 doubles.
// Each frame is a run of elements ending with in_last. The block reports the
// largest element, copied bit-exactly, together with its zero-based position.
// Ties keep the earliest element. NaNs lose to any non-NaN value.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_a, in_last       - element and end-of-frame flag (valid with in_a_stb)
//   in_a_stb, in_a_ack  - input handshake
//   out_z, out_idx      - frame maximum and its index (valid with out_z_stb)
//   out_z_stb, out_z_ack- result handshake
module double_max_stream #(
  parameter int unsigned IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      in_a,
  input  logic             in_a_stb,
  output logic             in_a_ack,
  input  logic             in_last,
  output logic [63:0]      out_z,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_z_stb,
  input  logic             out_z_ack
);

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACC   = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [63:0]      max_d;
  logic [IDX_W-1:0] idx_d;
  logic             ack_d, stb_d;
  logic             xfer_in, take_new;

  // NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  // IEEE-754 ordered greater-than on raw bit patterns.
  function automatic logic fp_gt(input logic [63:0] a, input logic [63:0] b);
    logic gt;
    gt = 1'b0;
    if (is_nan(a) || is_nan(b)) begin
      gt = 1'b0;
    end else if ((a[62:0] == 63'd0) && (b[62:0] == 63'd0)) begin
      gt = 1'b0;
    end else if (a[63] != b[63]) begin
      gt = !a[63];
    end else if (!a[63]) begin
      gt = a[62:0] > b[62:0];
    end else begin
      gt = a[62:0] < b[62:0];
    end
    return gt;
  endfunction

  assign xfer_in  = in_a_stb && in_a_ack;
  // A NaN running max is displaced by the first non-NaN element.
  assign take_new = fp_gt(in_a, out_z) || (is_nan(out_z) && !is_nan(in_a));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = out_z;
    idx_d   = out_idx;
    case (state_q)
      FIRST: begin
        if (xfer_in) begin
          max_d   = in_a;
          idx_d   = '0;
          count_d = IDX_W'(1);
          state_d = in_last ? OUT : ACC;
        end
      end
      ACC: begin
        if (xfer_in) begin
          if (take_new) begin
            max_d = in_a;
            idx_d = count_q;
          end
          count_d = count_q + IDX_W'(1);
          if (in_last) state_d = OUT;
        end
      end
      OUT: begin
        if (out_z_stb && out_z_ack) state_d = FIRST;
      end
      default: state_d = FIRST;
    endcase
    ack_d = (state_d != OUT);
    stb_d = (state_d == OUT);
  end

  // State and output registers; reset discards any partial frame or result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FIRST;
      count_q   <= '0;
      out_z     <= 64'd0;
      out_idx   <= '0;
      out_z_stb <= 1'b0;
      in_a_ack  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      out_z     <= max_d;
      out_idx   <= idx_d;
      out_z_stb <= stb_d;
      in_a_ack  <= ack_d;
    end
  end

endmodule

// File: doc/double_max_stream.md
DOUBLE_MAX_STREAM -- requirements
Module: double_max_stream

Interface
REQ-001 SHALL have parameter IDX_W, default 16, the width of the element index counter and out_idx.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_a, input, 64 bits: IEEE-754 double operand.
REQ-005 SHALL have port in_a_stb, input, 1 bit: in_a and in_last valid.
REQ-006 SHALL have port in_a_ack, output, 1 bit: block accepts an element this cycle.
REQ-007 SHALL have port in_last, input, 1 bit: the current element is the final one of its frame.
REQ-008 SHALL have port out_z, output, 64 bits: maximum of the frame, bit-exact copy of the winning input.
REQ-009 SHALL have port out_idx, output, IDX_W bits: zero-based position of the winning element within the frame.
REQ-010 SHALL have port out_z_stb, output, 1 bit: out_z and out_idx valid.
REQ-011 SHALL have port out_z_ack, input, 1 bit: consumer takes the result.

Function
REQ-012 SHALL transfer an input element on a rising edge where in_a_stb=1 and in_a_ack=1; the result SHALL transfer on a rising edge where out_z_stb=1 and out_z_ack=1.
REQ-013 SHALL implement states FIRST, ACC and OUT, with in_a_ack=1 in FIRST and ACC, in_a_ack=0 in OUT, and out_z_stb=1 only in OUT.
REQ-014 SHALL, on transfer in FIRST, load max=in_a and idx=0, set count=1, and move to OUT if in_last=1, else to ACC.
REQ-015 SHALL, on transfer in ACC, replace max with in_a and idx with count when in_a is GT max, or when max is NaN and in_a is not NaN; count SHALL increment by 1.
REQ-016 SHALL, on a transfer in ACC with in_last=1, apply REQ-015 to that element, then move to OUT.
REQ-017 SHALL, in OUT, hold out_z/out_idx stable until the result transfers, then return to FIRST on the next edge; no input SHALL be accepted in OUT.
REQ-018 SHALL assert out_z_stb exactly 1 cycle after the edge that transferred the last element, giving a latency of 1 cycle.
REQ-019 SHALL define GT as IEEE-754 greater-than: false if either operand is NaN (exp=0x7FF, mantissa!=0); +0 and -0 equal; positive operands compared by unsigned magnitude; negative operands compared by reversed magnitude; positive > negative unless both are zero; infinities ordered normally.
REQ-020 SHALL keep the earliest index on ties (equal values, including +0 vs -0).
REQ-021 SHALL output a NaN as out_z only if every element of the frame was NaN; out_z SHALL then be the first element and out_idx SHALL be 0.
REQ-022 SHALL wrap count modulo 2^IDX_W for frames longer than 2^IDX_W elements; out_idx SHALL be the wrapped value, with no error flag.
REQ-023 SHALL sustain 1 element per cycle in FIRST/ACC and SHALL ignore in_a_stb=0 cycles without changing state.
REQ-024 SHALL ignore in_a, in_last and in_a_stb while in_a_ack=0.
REQ-025 SHALL ignore out_z_ack while out_z_stb=0.

Reset
REQ-026 SHALL, on any edge with rst=1, force state=FIRST, count=0, out_z=0, out_idx=0, out_z_stb=0 and in_a_ack=0, overriding any simultaneous handshake.
REQ-027 SHALL drive in_a_ack=1 on the first edge after rst returns to 0.
REQ-028 SHALL, if reset is asserted mid-frame or in OUT, discard the partial frame or pending result; no out_z_stb pulse for it SHALL appear after reset.

Verification
REQ-029 SHALL pass frame {3FF0000000000000, 4000000000000000, BFF0000000000000} (last on 3rd), out_z_ack=1 -> out_z_stb=1 one cycle after 3rd transfer, out_z=4000000000000000, out_idx=1.
REQ-030 SHALL pass frame {8000000000000000, 0000000000000000} -> out_z=8000000000000000, out_idx=0 (tie keeps earliest); frame {7FF8000000000000, FFF0000000000000} -> out_z=FFF0000000000000, out_idx=1.
REQ-031 SHALL pass single-element frame {7FF0000000000000, in_last=1} -> out_z=7FF0000000000000, out_idx=0, in_a_ack=0 while out_z_stb=1.
REQ-032 SHALL pass a result held with out_z_ack=0 for 5 cycles -> out_z_stb, out_z and out_idx stable; ack on cycle 6 -> in_a_ack=1 next cycle.
REQ-033 SHALL pass rst=1 for 1 cycle after 2 of 4 elements -> no result, and a new frame {C000000000000000, C008000000000000} -> out_z=C000000000000000, out_idx=0.
REQ-034 SHALL pass in_a_stb toggling 1/0 each cycle over a 6-element frame {1.0, 2.0, 6.0, 3.0, 4.0, 5.0} -> out_idx=2, out_z=4018000000000000.
